// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
//
// Purpose : Shared timing constants and a counter-width helper for the
//           multi-channel button debouncer (btn_debouncer_multi and
//           btn_debounce_chan).
//
// Contents:
//   DEBOUNCE_5MS_100MHZ  - 5 ms stability window at 100 MHz
//   REPEAT_DELAY_500MS   - 500 ms hold before the first auto-repeat
//   REPEAT_PERIOD_100MS  - 100 ms between later auto-repeats
//   cnt_width(n)         - bits needed for a counter running 0..n-1
// ---------------------------------------------------------------------------
package btn_pkg;

    localparam int DEBOUNCE_5MS_100MHZ = 500_000;
    localparam int REPEAT_DELAY_500MS  = 50_000_000;
    localparam int REPEAT_PERIOD_100MS = 10_000_000;

    // A counter that only has to reach n-1 needs clog2(n) bits. The width is
    // never allowed below 1 so that tiny settings still produce a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : btn_pkg

// File: rtl/btn_debounce_chan.sv
// ---------------------------------------------------------------------------
// btn_debounce_chan
//
// Purpose : One debounced button channel. The raw input is synchronised,
//           filtered by a consecutive-cycle stability counter, and turned
//           into a registered level plus one-cycle press/release pulses.
//
// Optional: `define BTN_REPEAT_EN adds auto-repeat press pulses while the
//           debounced level stays high. Without it, the REPEAT_* parameters
//           are only range-checked and generate no logic.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   btn_in      in   raw asynchronous button input
//   btn_level   out  debounced stable state
//   btn_press   out  one-cycle pulse on a debounced 0->1 (and on repeats)
//   btn_release out  one-cycle pulse on a debounced 1->0
// ---------------------------------------------------------------------------
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_100MHZ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    // Elaboration-time range checks; they compile to nothing when legal.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce_chan: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser: a pure shift chain, nothing combinational before the
    // last stage so metastability gets the full chain to resolve.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples the pre-edge values of the others; blocking here would collapse
    // the chain into a single stage in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stability filter. The counter measures how many consecutive cycles
    // the synchronised input has disagreed with the stable level; any
    // agreement clears it, so a glitch restarts the whole window.
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          mismatch;
    logic          flip;
    logic          rise;
    logic          fall;

    assign mismatch = sync ^ level_q;
    assign flip     = mismatch && (cnt_q == CNT_LAST);
    assign rise     = flip & ~level_q;
    assign fall     = flip &  level_q;

    // NOTE: every signal driven from always_comb gets a default at the top of
    // the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!mismatch || flip) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (flip) begin
            level_d = ~level_q;
        end
    end

`ifdef BTN_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat. The counter runs only while the level is high; it is
    // held at zero while low, so it starts from zero on the press edge.
    // The first interval is REPEAT_DELAY, later ones REPEAT_PERIOD; the
    // armed flag selects which threshold applies.
    // ------------------------------------------------------------------
    localparam int              REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                            REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RW        = cnt_width(REP_MAX);
    localparam logic [RW-1:0]   REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_armed_q, rep_armed_d;
    logic          rep_fire;

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (!level_q || fall) begin
            // Low level, or a release landing on this edge: a release beats
            // a repeat that would otherwise fire in the same cycle.
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (rep_cnt_q == (rep_armed_q ? REP_NEXT : REP_FIRST)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
        end else begin
            rep_cnt_d   = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    assign press_d = rise | rep_fire;
`else
    assign press_d = rise;
`endif

    // Pulses are registered on the same edge that flips the level, so they
    // coincide exactly with the first cycle of the new level.
    assign release_d = fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule : btn_debounce_chan

// File: rtl/btn_debouncer_multi.sv
// ---------------------------------------------------------------------------
// btn_debouncer_multi
//
// Purpose : NUM_BTNS independent debounced button channels for feeding
//           control FSMs. Each bit of btn_in is handled by its own
//           btn_debounce_chan; there is no interaction or arbitration
//           between channels.
//
// Optional: `define BTN_REPEAT_EN enables auto-repeat press pulses on held
//           buttons (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   btn_in      in   [NUM_BTNS-1:0] raw asynchronous button inputs
//   btn_level   out  [NUM_BTNS-1:0] debounced stable state
//   btn_press   out  [NUM_BTNS-1:0] one-cycle debounced press pulses
//   btn_release out  [NUM_BTNS-1:0] one-cycle debounced release pulses
// ---------------------------------------------------------------------------
module btn_debouncer_multi
    import btn_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_100MHZ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    if (NUM_BTNS < 1) begin : g_bad_num
        $error("btn_debouncer_multi: NUM_BTNS must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule : btn_debouncer_multi

// File: tb/tb_btn_debouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_btn_debouncer_multi
//
// Directed bench for btn_debouncer_multi with NUM_BTNS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. A step driven before
// edge N shows on btn_level at edge N+5. Inputs change and outputs are
// sampled on the falling edge. Repeat expectations follow BTN_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_btn_debouncer_multi;

    localparam int NB = 4;

`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debouncer_multi #(
        .NUM_BTNS        (NB),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and land on the following falling edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [NB-1:0] obs,
                         input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [NB-1:0] lvl,
                             input logic [NB-1:0] prs, input logic [NB-1:0] rel);
        check({tag, ".level"},   btn_level,   lvl);
        check({tag, ".press"},   btn_press,   prs);
        check({tag, ".release"}, btn_release, rel);
    endtask

    initial begin
        logic [NB-1:0] exp_p;
        rst    = 1'b1;
        btn_in = '0;
        @(negedge clk);
        step(2);
        check_all("reset", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;

        // 1. Clean step on channel 0.
        btn_in = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all("t1.wait", 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_all("t1.edge", 4'b0001, 4'b0001, 4'b0000);
        step();
        check_all("t1.after", 4'b0001, 4'b0000, 4'b0000);
        btn_in = 4'b0000;
        step(5);
        check_all("t1.rel_wait", 4'b0001, 4'b0000, 4'b0000);
        step();
        check_all("t1.rel", 4'b0000, 4'b0000, 4'b0001);
        step();
        check_all("t1.rel_after", 4'b0000, 4'b0000, 4'b0000);

        // 2. Bounce on channel 1: 1,0,1,0 for two cycles each, then hold 1.
        for (int b = 0; b < 4; b++) begin
            btn_in = (b % 2 == 0) ? 4'b0010 : 4'b0000;
            for (int k = 0; k < 2; k++) begin
                step();
                check_all("t2.bounce", 4'b0000, 4'b0000, 4'b0000);
            end
        end
        btn_in = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all("t2.wait", 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_all("t2.edge", 4'b0010, 4'b0010, 4'b0000);
        btn_in = 4'b0000;
        step(6);
        check_all("t2.rel", 4'b0000, 4'b0000, 4'b0010);

        // 3. Channel 2 high, 3-cycle low glitch ignored, then real release.
        btn_in = 4'b0100;
        step(6);
        check_all("t3.press", 4'b0100, 4'b0100, 4'b0000);
        step();
        btn_in = 4'b0000;
        step(3);
        btn_in = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_all("t3.glitch", 4'b0100, 4'b0000, 4'b0000);
        end
        btn_in = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all("t3.rel_wait", 4'b0100, 4'b0000, 4'b0000);
        end
        step();
        check_all("t3.rel", 4'b0000, 4'b0000, 4'b0100);
        step();
        check_all("t3.rel_after", 4'b0000, 4'b0000, 4'b0000);

        // 4. All channels pressed together.
        btn_in = 4'b1111;
        step(5);
        check_all("t4.wait", 4'b0000, 4'b0000, 4'b0000);
        step();
        check_all("t4.edge", 4'b1111, 4'b1111, 4'b0000);
        step();
        check_all("t4.after", 4'b1111, 4'b0000, 4'b0000);
        btn_in = 4'b0000;
        step(6);
        check_all("t4.rel", 4'b0000, 4'b0000, 4'b1111);

        // 5. Reset while channel 3 is mid-count and channel 0 is high.
        btn_in = 4'b0001;
        step(6);
        check_all("t5.ch0", 4'b0001, 4'b0001, 4'b0000);
        btn_in = 4'b1001;
        step(4);
        check_all("t5.pre_rst", 4'b0001, 4'b0000, 4'b0000);
        rst = 1'b1;
        step();
        check_all("t5.rst", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all("t5.wait", 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_all("t5.edge", 4'b1001, 4'b1001, 4'b0000);

        // 6. Hold channels 0 and 3; repeats at +20, +28, ... only with the
        //    macro. Inputs drop before edge +62, so release lands at +67.
        for (int k = 1; k <= 67; k++) begin
            if (k == 62) btn_in = 4'b0000;
            step();
            exp_p = (REP && k >= 20 && k < 67 && (k - 20) % 8 == 0) ? 4'b1001 : 4'b0000;
            check_all("t6.hold", (k < 67) ? 4'b1001 : 4'b0000, exp_p,
                      (k == 67) ? 4'b1001 : 4'b0000);
        end
        step();
        check_all("t6.end", 4'b0000, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_btn_debouncer_multi
